// File: rtl/descriptor_memory_arbiter_if.sv
// rtl/descriptor_memory_arbiter_if.sv - Avalon-MM burst slave port bundle for one arbiter requester
interface descriptor_memory_arbiter_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/descriptor_memory_arbiter.sv
// rtl/descriptor_memory_arbiter.sv - round-robin burst arbiter sharing one descriptor RAM between two masters
module descriptor_memory_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  descriptor_memory_arbiter_if.slave s0,
  descriptor_memory_arbiter_if.slave s1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t             state, state_nx;
  logic               owner, owner_nx;
  logic               last_owner, last_owner_nx;
  logic [ADDR_W-1:0]  addr_cnt, addr_cnt_nx;
  logic [BURST_W-1:0] beats_left, beats_left_nx;

  logic [1:0]         req_rd, req_wr, req, accept;
  logic               gnt, cmd_wr, issue_rd, issue_port;
  logic [BURST_W-1:0] bc;

  logic [ADDR_W-1:0]  p_addr  [2];
  logic [DATA_W-1:0]  p_wdata [2];
  logic [BE_W-1:0]    p_be    [2];
  logic [BURST_W-1:0] p_bc    [2];

  logic [1:0]         rdv_q;
  logic [DATA_W-1:0]  rdata_q [2];

  assign req_rd     = {s1.read, s0.read};
  assign req_wr     = {s1.write, s0.write};
  assign p_addr[0]  = s0.address;
  assign p_addr[1]  = s1.address;
  assign p_wdata[0] = s0.writedata;
  assign p_wdata[1] = s1.writedata;
  assign p_be[0]    = s0.byteenable;
  assign p_be[1]    = s1.byteenable;
  assign p_bc[0]    = s0.burstcount;
  assign p_bc[1]    = s1.burstcount;

  assign mem_clken  = 1'b1;

  always_comb begin
    state_nx       = state;
    owner_nx       = owner;
    last_owner_nx  = last_owner;
    addr_cnt_nx    = addr_cnt;
    beats_left_nx  = beats_left;
    accept         = 2'b00;
    issue_rd       = 1'b0;
    issue_port     = owner;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_cnt;
    mem_writedata  = p_wdata[owner];
    mem_byteenable = '1;

    // On contention the port that did not win last time is served; a port's write beats its own read.
    req    = req_rd | req_wr;
    gnt    = (req == 2'b11) ? ~last_owner : req[1];
    cmd_wr = req_wr[gnt];
    bc     = (p_bc[gnt] == '0) ? BURST_W'(1) : p_bc[gnt];

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          accept[gnt]    = 1'b1;
          owner_nx       = gnt;
          last_owner_nx  = gnt;
          mem_chipselect = 1'b1;
          mem_write      = cmd_wr;
          mem_address    = p_addr[gnt];
          addr_cnt_nx    = p_addr[gnt] + ADDR_W'(1);
          beats_left_nx  = bc - BURST_W'(1);
          if (cmd_wr) begin
            mem_writedata  = p_wdata[gnt];
            mem_byteenable = p_be[gnt];
          end else begin
            issue_rd   = 1'b1;
            issue_port = gnt;
          end
          if (bc > BURST_W'(1)) state_nx = cmd_wr ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        mem_chipselect = 1'b1;
        issue_rd       = 1'b1;
        addr_cnt_nx    = addr_cnt + ADDR_W'(1);
        beats_left_nx  = beats_left - BURST_W'(1);
        if (beats_left == BURST_W'(1)) state_nx = IDLE;
      end
      WR_BURST: begin
        // The lock is held across gaps; only cycles with write asserted consume a beat.
        if (req_wr[owner]) begin
          accept[owner]  = 1'b1;
          mem_chipselect = 1'b1;
          mem_write      = 1'b1;
          mem_byteenable = p_be[owner];
          addr_cnt_nx    = addr_cnt + ADDR_W'(1);
          beats_left_nx  = beats_left - BURST_W'(1);
          if (beats_left == BURST_W'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (reset) begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      accept         = 2'b00;
      issue_rd       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr_cnt   <= '0;
      beats_left <= '0;
      rdv_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      addr_cnt   <= addr_cnt_nx;
      beats_left <= beats_left_nx;
      rdv_q      <= {issue_rd & issue_port, issue_rd & ~issue_port};
      if (rdv_q[0]) rdata_q[0] <= mem_readdata;
      if (rdv_q[1]) rdata_q[1] <= mem_readdata;
    end
  end

  assign s0.waitrequest   = ~accept[0];
  assign s1.waitrequest   = ~accept[1];
  assign s0.readdatavalid = rdv_q[0] & ~reset;
  assign s1.readdatavalid = rdv_q[1] & ~reset;
  assign s0.readdata      = rdv_q[0] ? mem_readdata : rdata_q[0];
  assign s1.readdata      = rdv_q[1] ? mem_readdata : rdata_q[1];
endmodule

// File: doc/descriptor_memory_arbiter.md
# descriptor_memory_arbiter

Two-port Avalon-MM arbiter that shares the single-port 1024 x 32 on-chip descriptor RAM between a CPU data master (port 0) and the SGDMA descriptor master (port 1). The RAM accepts one access per clock and returns read data one cycle after the address edge. This block grants the RAM round-robin at burst granularity, generates burst addresses and returns read data with readdatavalid. It sits between the system interconnect and the RAM's s1 slave.

## Interface
- ADDR_W, 10, word address width (RAM depth 2^ADDR_W)
- DATA_W, 32, data width
- BURST_W, 4, burstcount width (bursts of 1..15 words)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sN_address  in  ADDR_W  word address of first beat (N = 0, 1; all sN_ ports are duplicated per port)
- sN_read / sN_write  in  1  read command / write beat request
- sN_writedata  in  DATA_W  write data
- sN_byteenable  in  DATA_W/8  byte lanes for write
- sN_burstcount  in  BURST_W  words in burst; 0 treated as 1
- sN_waitrequest  out  1  command/beat not accepted this cycle
- sN_readdata  out  DATA_W  read data
- sN_readdatavalid  out  1  sN_readdata valid
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  DATA_W/8  RAM byte enables
- mem_chipselect / mem_write  out  1  RAM access / write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  RAM read data, valid cycle after address edge

## Operation
- States: IDLE, RD_BURST, WR_BURST. Registers: owner, last_owner, addr_cnt (ADDR_W), beats_left (BURST_W).
- IDLE: requester = port with sN_read or sN_write high. If both request, grant the port != last_owner. The granted port's command is accepted this cycle: sN_waitrequest=0, mem_* driven from its inputs, owner and last_owner updated.
- Same port asserting read and write together: write wins; read stays pending.
- Read accept (burstcount B): beat 0 is issued in the accept cycle. If B>1, go to RD_BURST with addr_cnt = address+1 and beats_left = B-1. Each RD_BURST cycle issues mem_address=addr_cnt and increments addr_cnt. The last beat returns to IDLE.
- Owner's sN_waitrequest stays 1 during RD_BURST; the owner may not issue a new command until its burst is fully issued.
- Write accept: beat 0 is written in the accept cycle. If B>1, go to WR_BURST. Each cycle with owner sN_write=1 writes at addr_cnt with sN_writedata/sN_byteenable, waitrequest=0, and decrements beats_left. Idle cycles (sN_write=0) hold the lock and write nothing. The last beat returns to IDLE.
- Addresses wrap modulo 2^ADDR_W: 1023+1 -> 0.
- Read return: mem_readdata of each issued read beat is routed to the issuing port's sN_readdata with sN_readdatavalid=1 exactly one cycle later. The tag is a 1-cycle registered owner/valid pipeline.
- The non-owner's sN_waitrequest is 1 while a burst is locked. In IDLE with no grant to a port, that port's sN_waitrequest=1.
- Reset mid-burst: next cycle is IDLE, the burst is abandoned, and no readdatavalid follows for beats issued in the reset cycle.

## Timing
- Reset values: state=IDLE, last_owner=1 (port 0 wins first contention), sN_waitrequest=1, sN_readdatavalid=0, sN_readdata=0, mem_chipselect=0, mem_write=0. mem_chipselect=0 throughout any cycle with reset=1.
- mem_* outputs are combinational from the granted port in the accept cycle and from addr_cnt in burst cycles.
- Read latency: accept cycle T, beats issued T..T+B-1, readdatavalid T+1..T+B.
- Next grant is possible in cycle T+B, overlapping the last readdatavalid.
- Throughput: 1 word/clock. Arbitration adds no idle cycle between bursts.
- sN_readdata holds its last value when sN_readdatavalid=0.

## Test plan
- Single read: after reset, s0 read addr 5, burstcount 1, RAM[5]=0xDEADBEEF -> waitrequest 0 at T, s0_readdatavalid=1 and s0_readdata=0xDEADBEEF at T+1.
- Contention: s0 and s1 read simultaneously -> s0 granted first. On the next simultaneous request, s1 is granted (last_owner alternates). s1_waitrequest=1 during s0's burst.
- Read burst wrap: s1 read addr 1022, burstcount 4 -> mem_address 1022, 1023, 0, 1 on consecutive cycles; 4 readdatavalid pulses on s1 only, one cycle later each.
- Write burst with gaps: s0 write addr 100, burstcount 3, byteenable 0x3 on beat 2, one idle cycle between beats -> RAM[100..102] written with correct lanes; s1 request stays blocked until the 3rd beat is accepted.
- Reset mid-burst: assert reset during beat 2 of an 8-beat read -> no further readdatavalid, all outputs at reset values, and a new s1 read is accepted in the first cycle after reset.
- burstcount 0: s0 write with burstcount 0 -> exactly one word written, immediate return to IDLE.
